// File: rtl/bip_pkg.sv
// Shared BIP definitions: field widths, opcode values and program loader state encoding.
package bip_pkg;

   localparam int unsigned OPCODE_WIDTH = 5;
   localparam int unsigned ADDR_WIDTH   = 11;
   localparam int unsigned INSTR_WIDTH  = OPCODE_WIDTH + ADDR_WIDTH;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      HLT  = 5'd0,
      STO  = 5'd1,
      LD   = 5'd2,
      LDI  = 5'd3,
      ADD  = 5'd4,
      ADDI = 5'd5,
      SUB  = 5'd6,
      SUBI = 5'd7
   } opcode_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_HI = 3'd1,
      WAIT_LO = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4,
      ERR     = 3'd5
   } loaderState_t;

endpackage

// File: rtl/bip_program_loader.sv
// Assembles high/low byte pairs from the receiver into instruction words and writes them
// to program memory from address 0, holding the CPU in reset until an HLT has been stored.
module bip_program_loader #(
   parameter int unsigned ADDR_WIDTH   = bip_pkg::ADDR_WIDTH,
   parameter int unsigned INSTR_WIDTH  = bip_pkg::INSTR_WIDTH,
   parameter int unsigned OPCODE_WIDTH = bip_pkg::OPCODE_WIDTH,
   parameter int unsigned MAX_OPCODE   = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    Start,
   input  logic [7:0]              RxData,
   input  logic                    RxValid,
   output logic [ADDR_WIDTH-1:0]   PmAddr,
   output logic [INSTR_WIDTH-1:0]  PmData,
   output logic                    PmWr,
   output logic                    CpuRst,
   output logic                    Done,
   output logic                    Error,
   output logic [ADDR_WIDTH:0]     WordCount
);
   import bip_pkg::*;

   localparam int unsigned COUNT_WIDTH = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   loaderState_t state, stateNext;
   logic [15:0] word;
   logic [OPCODE_WIDTH-1:0] rxOpcode;
   logic rxIllegal;
   logic wordIsHlt;

   assign rxOpcode  = RxData[7 -: OPCODE_WIDTH];
   assign rxIllegal = 32'(rxOpcode) > MAX_OPCODE;
   assign wordIsHlt = word[15 -: OPCODE_WIDTH] == OPCODE_WIDTH'(HLT);
   assign PmData    = INSTR_WIDTH'(word);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Next state; Start restarts from any state and takes priority over a byte
   always_comb begin
      stateNext = state;
      if (Start) begin
         stateNext = WAIT_HI;
      end else begin
         case (state)
            WAIT_HI: if (RxValid) stateNext = rxIllegal ? ERR : WAIT_LO;
            WAIT_LO: if (RxValid) stateNext = WRITE;
            WRITE: begin
               if (RxValid)                 stateNext = ERR;
               else if (wordIsHlt)          stateNext = DONE;
               else if (PmAddr == LAST_ADDR) stateNext = ERR;
               else                          stateNext = WAIT_HI;
            end
            default: stateNext = state;
         endcase
      end
   end

   // Registered outputs, address counter and word assembly
   always_ff @(posedge clk) begin
      if (reset) begin
         PmWr      <= 1'b0;
         CpuRst    <= 1'b1;
         Done      <= 1'b0;
         Error     <= 1'b0;
         PmAddr    <= '0;
         WordCount <= '0;
         word      <= '0;
      end else begin
         PmWr   <= stateNext == WRITE;
         Done   <= stateNext == DONE;
         Error  <= stateNext == ERR;
         CpuRst <= stateNext != DONE;
         if (Start) begin
            PmAddr    <= '0;
            WordCount <= '0;
         end else if (state == WRITE) begin
            WordCount <= WordCount + COUNT_WIDTH'(1);
            if (stateNext == WAIT_HI) PmAddr <= PmAddr + ADDR_WIDTH'(1);
         end
         if (!Start && RxValid) begin
            if (state == WAIT_HI) word[15:8] <= RxData;
            if (state == WAIT_LO) word[7:0]  <= RxData;
         end
      end
   end

endmodule

// File: tb/tb_bip_program_loader.sv
// Randomized and directed bench for bip_program_loader against a byte-list reference model.
module tb_bip_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [7:0]  RxData;
   logic        RxValid;
   logic [10:0] PmAddr;
   logic [15:0] PmData;
   logic        PmWr;
   logic        CpuRst;
   logic        Done;
   logic        Error;
   logic [11:0] WordCount;

   int checks = 0;
   int errors = 0;

   logic [26:0] capQ[$];
   logic [26:0] expQ[$];
   logic [7:0]  txBytes[$];
   logic        bothSet = 1'b0;
   logic        expDone, expErr;
   int          expAddr, expCount;

   bip_program_loader dut (
      .clk(clk), .reset(reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
      .PmAddr(PmAddr), .PmData(PmData), .PmWr(PmWr), .CpuRst(CpuRst),
      .Done(Done), .Error(Error), .WordCount(WordCount)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (PmWr) capQ.push_back({PmAddr, PmData});
      if (Done && Error) bothSet = 1'b1;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected memory image and final status for the byte stream that follows one Start
   task automatic model();
      expQ.delete();
      expDone = 1'b0; expErr = 1'b0; expAddr = 0; expCount = 0;
      for (int i = 0; 2 * i < txBytes.size(); i++) begin
         expAddr = i;
         if (int'(txBytes[2*i][7:3]) > 7) begin expErr = 1'b1; return; end
         if (2 * i + 1 >= txBytes.size()) return;
         expQ.push_back({11'(i), txBytes[2*i], txBytes[2*i+1]});
         expCount++;
         if (txBytes[2*i][7:3] == 5'd0) begin expDone = 1'b1; return; end
         if (i == 2047) begin expErr = 1'b1; return; end
      end
      expAddr = txBytes.size() / 2;
   endtask

   task automatic startLoad();
      @(negedge clk); Start = 1'b1;
      @(negedge clk); Start = 1'b0;
      capQ.delete();
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      @(negedge clk); RxData = b; RxValid = 1'b1;
      @(negedge clk); RxValid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic sendAll(input bit randGap);
      foreach (txBytes[k]) sendByte(txBytes[k], randGap ? int'($urandom_range(0, 2)) : 0);
   endtask

   task automatic finishLoad(input string tag);
      repeat (4) @(negedge clk);
      checkVal({tag, ".nwr"}, capQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < capQ.size(); i++)
         checkVal($sformatf("%s.wr%0d", tag, i), 32'(capQ[i]), 32'(expQ[i]));
      checkVal({tag, ".done"}, 32'(Done), 32'(expDone));
      checkVal({tag, ".err"}, 32'(Error), 32'(expErr));
      checkVal({tag, ".cpurst"}, 32'(CpuRst), 32'(!expDone));
      checkVal({tag, ".count"}, 32'(WordCount), 32'(expCount));
      checkVal({tag, ".addr"}, 32'(PmAddr), 32'(expAddr));
      checkVal({tag, ".both"}, 32'(bothSet), 32'(0));
   endtask

   task automatic checkResetValues(input string tag);
      checkVal({tag, ".state"}, {PmWr, CpuRst, Done, Error}, 32'b0100);
      checkVal({tag, ".addr"}, 32'(PmAddr), 32'(0));
      checkVal({tag, ".data"}, 32'(PmData), 32'(0));
      checkVal({tag, ".count"}, 32'(WordCount), 32'(0));
   endtask

   initial begin
      reset = 1'b1; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
      repeat (2) @(negedge clk);
      checkResetValues("rst");
      reset = 1'b0;

      // Bytes in IDLE are ignored
      sendByte(8'h00, 0); sendByte(8'h00, 2);
      checkVal("idle.nwr", capQ.size(), 0);
      checkVal("idle.done", 32'(Done), 32'(0));

      // Normal load
      txBytes = '{8'h10, 8'h05, 8'h20, 8'h05, 8'h00, 8'h00};
      startLoad(); model(); sendAll(1'b0); finishLoad("normal");

      // Illegal opcode, following byte ignored
      txBytes = '{8'h40, 8'h00, 8'h00};
      startLoad(); model(); sendAll(1'b0); finishLoad("illegal");

      // Overrun: byte arrives during the write cycle
      startLoad();
      sendByte(8'h18, 0);
      @(negedge clk); RxData = 8'h01; RxValid = 1'b1;
      @(negedge clk); RxData = 8'h55;
      @(negedge clk); RxValid = 1'b0;
      expQ.delete(); expQ.push_back({11'd0, 16'h1801});
      expDone = 1'b0; expErr = 1'b1; expCount = 1; expAddr = 0;
      finishLoad("overrun");

      // Mid-load restart discards the partial word
      startLoad(); sendByte(8'h30, 1);
      txBytes = '{8'h28, 8'h07, 8'h00, 8'h00};
      startLoad(); model(); sendAll(1'b0); finishLoad("restart");

      // Reset mid-word
      startLoad(); sendByte(8'h38, 0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      checkResetValues("midrst");
      sendByte(8'h00, 0); sendByte(8'h00, 3);
      checkVal("midrst.nwr", capQ.size(), 0);
      checkVal("midrst.cpurst", 32'(CpuRst), 32'(1));

      // Randomized programs, each started without waiting for the previous to finish
      for (int t = 0; t < 20; t++) begin
         int nWords;
         nWords = int'($urandom_range(1, 12));
         txBytes.delete();
         for (int w = 0; w < nWords; w++) begin
            logic [4:0] op;
            op = 5'($urandom_range(1, 8));
            if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(0, 31));
            txBytes.push_back({op, 3'($urandom)});
            txBytes.push_back(8'($urandom));
         end
         if ($urandom_range(0, 3) != 0) begin
            txBytes.push_back({5'd0, 3'($urandom)});
            txBytes.push_back(8'($urandom));
         end
         if ($urandom_range(0, 4) == 0) txBytes.push_back(8'h10);
         startLoad(); model(); sendAll(1'b1); finishLoad($sformatf("rnd%0d", t));
      end

      // Address space overflow: no wrap past the last address
      txBytes.delete();
      for (int w = 0; w < 2048; w++) begin
         txBytes.push_back({5'($urandom_range(1, 7)), 3'($urandom)});
         txBytes.push_back(8'($urandom));
      end
      startLoad(); model(); sendAll(1'b0); finishLoad("overflow");

      // Recovery after error
      txBytes = '{8'h08, 8'h11, 8'h00, 8'h00};
      startLoad(); model(); sendAll(1'b0); finishLoad("recover");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
